// File: rtl/csa_pkg.sv
// csa_pkg: shared word width and controller state encoding for the wide sequential adder
package csa_pkg;
   localparam int WW = 16;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/CarrySelectAdder.sv
// CarrySelectAdder: 16-bit adder of four 4-bit blocks, each precomputing both carry-in cases
module CarrySelectAdder (
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic        cin,
   output logic [15:0] S,
   output logic        cout
);
   logic [4:0] c;
   assign c[0] = cin;
   for (genvar g = 0; g < 4; g++) begin : blk
      logic [4:0] s0, s1;
      assign s0 = {1'b0, x[4*g +: 4]} + {1'b0, y[4*g +: 4]};
      assign s1 = s0 + 5'd1;
      assign S[4*g +: 4] = c[g] ? s1[3:0] : s0[3:0];
      assign c[g+1] = c[g] ? s1[4] : s0[4];
   end
   assign cout = c[4];
endmodule

// File: rtl/wide_add_seq.sv
// wide_add_seq: WORDS x 16-bit add/subtract computed one word per cycle, LSW first,
// through a single shared 16-bit adder with the carry held in a register between words
module wide_add_seq
   import csa_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WORDS*16-1:0]   in_a,
   input  logic [WORDS*16-1:0]   in_b,
   input  logic                  in_cin,
   input  logic                  in_sub,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WORDS*16-1:0]   out_sum,
   output logic                  out_cout,
   output logic                  busy
);
   localparam int IW = $clog2(WORDS);
   state_t state;
   logic [WORDS-1:0][WW-1:0] a_r, b_r, sum_r;
   logic [IW-1:0] idx;
   logic carry, co;
   logic [WW-1:0] s;
   CarrySelectAdder u_csa (.x(a_r[idx]), .y(b_r[idx]), .cin(carry), .S(s), .cout(co));
   assign in_ready = state == IDLE;
   assign busy     = state != IDLE;
   assign out_sum  = sum_r;
   // subtraction is A + ~B + 1, so B is stored inverted and the carry preset to 1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         a_r       <= '0;
         b_r       <= '0;
         sum_r     <= '0;
         idx       <= '0;
         carry     <= 1'b0;
         out_cout  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_r   <= in_a;
               b_r   <= in_sub ? ~in_b : in_b;
               idx   <= '0;
               carry <= in_sub ? 1'b1 : in_cin;
               state <= RUN;
            end
            RUN: begin
               sum_r[idx] <= s;
               carry      <= co;
               if (idx == IW'(WORDS-1)) begin
                  out_cout  <= co;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_wide_add_seq.sv
// tb_wide_add_seq: randomized and directed scoreboard bench for wide_add_seq (WORDS=4)
module tb_wide_add_seq;
   localparam int WORDS = 4;
   localparam int N = WORDS*16;
   logic clk = 0, rst_n = 0, in_valid = 0, in_cin = 0, in_sub = 0, out_ready = 1;
   logic [N-1:0] in_a = '0, in_b = '0;
   logic in_ready, out_valid, out_cout, busy;
   logic [N-1:0] out_sum;
   int checks = 0, failures = 0, cyc = 0, last_acc = 0;
   bit b2b = 0, have_last = 0, seen = 0;
   logic [N:0] sb[$];
   int acc_q[$];
   logic [N:0] held;

   wide_add_seq #(.WORDS(WORDS)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_cout(out_cout), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [N:0] act, input logic [N:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // reference: plain wide arithmetic; for subtract, carry means A >= B (no borrow)
   function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                        input logic c, input logic s);
      logic [N-1:0] d;
      d = a - b;
      return s ? {(a >= b), d} : ({1'b0, a} + {1'b0, b} + (N+1)'(c));
   endfunction

   always @(posedge clk) begin
      if (rst_n && in_valid && in_ready) begin
         sb.push_back(model(in_a, in_b, in_cin, in_sub));
         acc_q.push_back(cyc);
         if (b2b && have_last) chk("accept_spacing", 65'(cyc - last_acc), 65'(WORDS + 2));
         last_acc = cyc;
         have_last = 1;
      end
      cyc++;
   end

   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         chk("in_ready_low_in_done", 65'(in_ready), 65'(0));
         if (!seen) begin
            seen = 1;
            held = {out_cout, out_sum};
            if (acc_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL latency: result with no accepted request, got %0h", held);
            end else chk("latency", 65'(cyc - acc_q.pop_front() - 1), 65'(WORDS));
         end else chk("hold_stable", {out_cout, out_sum}, held);
         if (out_ready) begin
            seen = 0;
            if (sb.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_result: got %0h expected none", {out_cout, out_sum});
            end else chk("result", {out_cout, out_sum}, sb.pop_front());
         end
      end
   end

   task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                        input logic s, input bit hold);
      bit ok = 0;
      in_a = a; in_b = b; in_cin = c; in_sub = s; in_valid = 1;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
      end
      if (!ok) begin
         checks++; failures++;
         $display("FAIL accept_timeout: got in_ready=0 expected 1");
      end
      if (!hold) in_valid = 0;
   endtask

   task automatic drain();
      for (int n = 0; n < 200 && (sb.size() != 0 || !in_ready); n++) @(posedge clk);
      #1;
      chk("drain_empty", 65'(sb.size()), 65'(0));
   endtask

   function automatic logic [N-1:0] rnd();
      return {$urandom, $urandom};
   endfunction

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_sum", 65'(out_sum), 65'(0));
      chk("rst_out_cout", 65'(out_cout), 65'(0));
      chk("rst_out_valid", 65'(out_valid), 65'(0));
      chk("rst_busy", 65'(busy), 65'(0));
      rst_n = 1;
      #1 chk("in_ready_after_reset", 65'(in_ready), 65'(1));
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0);
      drain();
      chk("ripple_sum", 65'(out_sum), 65'(0));
      chk("ripple_cout", 65'(out_cout), 65'(1));
      issue(64'h0000_FFFF_0000_FFFF, 64'd0, 1'b1, 1'b0, 0);
      drain();
      chk("cin_sum", 65'(out_sum), 65'h0000_FFFF_0001_0000);
      issue(64'd5, 64'd7, 1'b1, 1'b1, 0);
      drain();
      chk("sub_borrow", {out_cout, out_sum}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
      issue(64'd7, 64'd5, 1'b0, 1'b1, 0);
      drain();
      chk("sub_noborrow", {out_cout, out_sum}, {1'b1, 64'd2});
      chk("idle_keeps_result", 65'(out_sum), 65'(2));
      // backpressure: result must hold and extra requests must be ignored
      out_ready = 0;
      issue(rnd(), rnd(), 1'($urandom), 1'b0, 0);
      for (int n = 0; n < 50 && !out_valid; n++) begin
         @(posedge clk);
         #1;
      end
      chk("bp_valid", 65'(out_valid), 65'(1));
      for (int k = 0; k < 3; k++) begin
         in_valid = 1;
         in_a = ~in_a;
         @(posedge clk);
         #1;
         in_valid = 0;
         chk("bp_in_ready", 65'(in_ready), 65'(0));
         chk("bp_no_accept", 65'(sb.size()), 65'(1));
      end
      out_ready = 1;
      drain();
      // reset in the middle of RUN
      issue(rnd(), rnd(), 1'b0, 1'b0, 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 0;
      #1;
      chk("midrun_out_sum", 65'(out_sum), 65'(0));
      chk("midrun_out_cout", 65'(out_cout), 65'(0));
      chk("midrun_out_valid", 65'(out_valid), 65'(0));
      chk("midrun_busy", 65'(busy), 65'(0));
      sb.delete();
      acc_q.delete();
      seen = 0;
      @(posedge clk);
      #1 rst_n = 1;
      #1 chk("midrun_in_ready", 65'(in_ready), 65'(1));
      issue(64'd1, 64'd2, 1'b0, 1'b0, 0);
      drain();
      chk("after_reset_sum", {out_cout, out_sum}, {1'b0, 64'd3});
      // back-to-back with in_valid held high
      have_last = 0;
      b2b = 1;
      for (int i = 0; i < 12; i++) issue(rnd(), rnd(), 1'($urandom), 1'($urandom), 1);
      in_valid = 0;
      drain();
      b2b = 0;
      for (int i = 0; i < 8; i++) begin
         issue(rnd(), (i == 0) ? 64'd0 : rnd(), 1'($urandom), 1'($urandom), 0);
         drain();
      end
      chk("scoreboard_empty", 65'(sb.size()), 65'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/wide_add_seq.md
WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 SHALL have parameter WORDS, default 4: number of 16-bit words per operand, legal range 2..16.
REQ-002 SHALL have ports as follows; clock and reset come first.
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept a request.
- in_a  input  WORDS*16  operand A.
- in_b  input  WORDS*16  operand B.
- in_cin  input  1  carry-in; used only when in_sub=0.
- in_sub  input  1  1 selects A-B, 0 selects A+B+cin.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WORDS*16  result.
- out_cout  output  1  final carry; for subtract, 1 means no borrow.
- busy  output  1  high in RUN or DONE.

Function
REQ-003 SHALL use one 16-bit adder for all words, processing one word per cycle from LSW to MSW, with the carry registered between words.
REQ-004 SHALL have states IDLE, RUN and DONE, with these transitions:
- IDLE->RUN on in_valid&&in_ready.
- RUN->DONE on the edge that processes word WORDS-1.
- DONE->IDLE on out_valid&&out_ready.
REQ-005 in_ready SHALL be 1 only in IDLE; in_valid in RUN or DONE SHALL be ignored and have no side effects.
REQ-006 On accept, the block SHALL capture in_a and in_b (B inverted if in_sub) into internal registers, set the word index to 0, and set carry to (in_sub ? 1 : in_cin).
REQ-007 Each RUN edge SHALL write word[idx] of out_sum with the 16-bit sum, load carry with that word's carry-out, and increment idx.
REQ-008 out_valid SHALL go high exactly WORDS rising edges after the accepting edge and stay high until the handshake completes.
REQ-009 While out_valid=1 and out_ready=0, out_sum and out_cout SHALL hold stable.
REQ-010 out_cout SHALL equal the carry-out of word WORDS-1 and be valid whenever out_valid=1.
REQ-011 out_sum and out_cout SHALL keep their last value after returning to IDLE, and change only in RUN.
REQ-012 Arithmetic SHALL be modulo 2^(WORDS*16); overflow is reported only via out_cout, with no separate signed overflow flag.
REQ-013 When out_ready is already 1 as DONE is entered, the block SHALL complete the handshake on the next edge and return to IDLE; minimum spacing between accepts is WORDS+2 cycles.
REQ-014 The word index SHALL be a counter of clog2(WORDS) bits that never wraps while in RUN.

Reset
REQ-015 Assertion of rst_n=0 SHALL, asynchronously in any state including mid-RUN, force state=IDLE, idx=0, carry=0, out_sum=0, out_cout=0, out_valid=0 and busy=0.
REQ-016 in_ready SHALL be 1 in the first cycle after rst_n deasserts; a partial operation interrupted by reset SHALL NOT produce an output.

Structure
REQ-017 A shared package csa_pkg SHALL hold the word-width constant (16) and the state enumeration {IDLE, RUN, DONE}.
REQ-018 The 16-bit datapath SHALL be one instance of the team's 16-bit carry-select adder module CarrySelectAdder (x, y, cin, S, cout), unmodified; the controller adds only registers and muxing.

Verification (WORDS=4)
REQ-019 The bench SHALL cover these directed scenarios:
- Add with full carry ripple: A=0xFFFF_FFFF_FFFF_FFFF, B=1, cin=0 -> out_sum=0, out_cout=1, out_valid 4 edges after accept.
- Carry-in through partial words: A=0x0000_FFFF_0000_FFFF, B=0, cin=1 -> out_sum=0x0000_FFFF_0001_0000, out_cout=0.
- Subtract with borrow: A=5, B=7, sub=1, cin=1 (cin ignored) -> out_sum=0xFFFF_FFFF_FFFF_FFFE, out_cout=0; A=7, B=5 -> out_sum=2, out_cout=1.
- Backpressure: out_ready held 0 for 3 cycles in DONE -> out_sum/out_cout stable, in_ready=0; a new in_valid pulse is not accepted.
- Reset mid-RUN: rst_n low after 2 RUN edges -> all outputs 0 immediately; next request A=1, B=2 -> out_sum=3.
- Back-to-back: in_valid held high with out_ready=1 -> accepts spaced exactly 6 cycles, every result correct against a 64-bit reference model.
